div_unit: RTL and testbench

- Iterative RV32M divider in the EX stage. Consumes the two source operands read from the ID-stage register file and executes DIV, DIVU, REM and REMU.
- Uses a start/busy/done handshake, so the hazard logic stalls the pipeline while busy is high.
- Restoring algorithm, one quotient bit per cycle; divide-by-zero and signed overflow take a fast path.

---
 rtl/div_pkg.sv | 33 +++
 rtl/div_special_chk.sv | 37 +++
 rtl/div_unit.sv | 232 +++++++++++++++++++++++
 tb/tb_div_unit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the iterative RV32M divider.
// Holds the op encodings, the datapath width, the FSM state type,
// the special-case constants and a small magnitude helper.
package div_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix,
    StDone
  } div_state_t;

  localparam logic [XLEN-1:0] DIV_ZERO_Q = '1;
  localparam logic [XLEN-1:0] INT_MIN    = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  // Two's-complement magnitude; INT_MIN maps to 0x80000000, which is
  // the correct unsigned magnitude.
  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic is_signed);
    return (is_signed && v[XLEN-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/div_special_chk.sv
// Combinational detector for the divider's fast-path cases.
// Ports:
//   op_i          operation (DIV/DIVU/REM/REMU)
//   rs1_i, rs2_i  dividend and divisor
//   is_special_o  divide-by-zero or signed overflow
//   spec_quo_o    quotient for the special case
//   spec_rem_o    remainder for the special case
module div_special_chk
  import div_pkg::*;
(
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            is_special_o,
  output logic [XLEN-1:0] spec_quo_o,
  output logic [XLEN-1:0] spec_rem_o
);

  logic is_signed;

  always_comb begin
    is_signed    = op_is_signed(op_i);
    is_special_o = 1'b0;
    spec_quo_o   = '0;
    spec_rem_o   = '0;
    if (rs2_i == '0) begin
      is_special_o = 1'b1;
      spec_quo_o   = DIV_ZERO_Q;
      spec_rem_o   = rs1_i;
    end else if (is_signed && (rs1_i == INT_MIN) && (rs2_i == DIV_ZERO_Q)) begin
      is_special_o = 1'b1;
      spec_quo_o   = INT_MIN;
      spec_rem_o   = '0;
    end
  end

endmodule

// File: rtl/div_unit.sv
// Iterative restoring RV32M divider (DIV, DIVU, REM, REMU) for the EX stage.
// One quotient bit per cycle; divide-by-zero and signed overflow complete in
// one cycle through div_special_chk.
// Ports:
//   clk       clock, rising edge
//   rst       synchronous active-low reset
//   start     request, sampled only when idle
//   op        00 DIV, 01 DIVU, 10 REM, 11 REMU
//   rs1_data  dividend
//   rs2_data  divisor
//   flush     abandon the current operation
//   busy      high while iterating / fixing up signs
//   done      one-cycle pulse with result valid
//   result    quotient or remainder, held until the next done
// Build option: define DIV_RESULT_CACHE_EN to keep the last completed
// operand pair and its quotient/remainder, so a repeat on the same operands
// (e.g. DIV then REM) completes in one cycle.
module div_unit
  import div_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ITER = XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CntW = $clog2(ITER);

  div_state_t      state_q, state_d;
  logic            rem_sel_q, rem_sel_d;
  logic            q_neg_q, q_neg_d;
  logic            r_neg_q, r_neg_d;
  logic [XLEN-1:0] divisor_q, divisor_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            is_special;
  logic [XLEN-1:0] spec_quo, spec_rem;
  logic            op_signed;
  logic [XLEN:0]   shifted, trial;
  logic [XLEN-1:0] q_fix, r_fix;
  logic            cache_hit;
  logic [XLEN-1:0] cache_res;

  div_special_chk u_special_chk (
    .op_i        (op),
    .rs1_i       (rs1_data),
    .rs2_i       (rs2_data),
    .is_special_o(is_special),
    .spec_quo_o  (spec_quo),
    .spec_rem_o  (spec_rem)
  );

  assign op_signed = op_is_signed(op);

`ifdef DIV_RESULT_CACHE_EN
  logic            signed_q, signed_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic [XLEN-1:0] rs2_q, rs2_d;
  logic            c_valid_q, c_valid_d;
  logic            c_signed_q, c_signed_d;
  logic [XLEN-1:0] c_rs1_q, c_rs1_d;
  logic [XLEN-1:0] c_rs2_q, c_rs2_d;
  logic [XLEN-1:0] c_quo_q, c_quo_d;
  logic [XLEN-1:0] c_rem_q, c_rem_d;

  assign cache_hit = c_valid_q && (rs1_data == c_rs1_q) && (rs2_data == c_rs2_q) &&
                     (op_signed == c_signed_q);
  assign cache_res = op[1] ? c_rem_q : c_quo_q;
`else
  assign cache_hit = 1'b0;
  assign cache_res = '0;
`endif

  always_comb begin
    state_d   = state_q;
    rem_sel_d = rem_sel_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    divisor_d = divisor_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
`ifdef DIV_RESULT_CACHE_EN
    signed_d   = signed_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    c_valid_d  = c_valid_q;
    c_signed_d = c_signed_q;
    c_rs1_d    = c_rs1_q;
    c_rs2_d    = c_rs2_q;
    c_quo_d    = c_quo_q;
    c_rem_d    = c_rem_q;
`endif

    // Shift {rem,quo} left and trial-subtract; the extra MSB is the borrow.
    shifted = {rem_q, quo_q[XLEN-1]};
    trial   = shifted - {1'b0, divisor_q};

    q_fix = q_neg_q ? (~quo_q + 1'b1) : quo_q;
    r_fix = r_neg_q ? (~rem_q + 1'b1) : rem_q;

    case (state_q)
      StIdle: begin
        if (start && !flush) begin
          rem_sel_d = op[1];
          q_neg_d   = op_signed && (rs1_data[XLEN-1] ^ rs2_data[XLEN-1]);
          r_neg_d   = op_signed && rs1_data[XLEN-1];
          divisor_d = abs_val(rs2_data, op_signed);
          quo_d     = abs_val(rs1_data, op_signed);
          rem_d     = '0;
          cnt_d     = CntW'(ITER - 1);
`ifdef DIV_RESULT_CACHE_EN
          signed_d  = op_signed;
          rs1_d     = rs1_data;
          rs2_d     = rs2_data;
`endif
          if (is_special) begin
            result_d = op[1] ? spec_rem : spec_quo;
            state_d  = StDone;
          end else if (cache_hit) begin
            result_d = cache_res;
            state_d  = StDone;
          end else begin
            state_d  = StCalc;
          end
        end
      end
      StCalc: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          quo_d = {quo_q[XLEN-2:0], ~trial[XLEN]};
          rem_d = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_d = StFix;
          end
        end
      end
      StFix: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          result_d = rem_sel_q ? r_fix : q_fix;
          state_d  = StDone;
`ifdef DIV_RESULT_CACHE_EN
          c_valid_d  = 1'b1;
          c_signed_d = signed_q;
          c_rs1_d    = rs1_q;
          c_rs2_d    = rs2_q;
          c_quo_d    = q_fix;
          c_rem_d    = r_fix;
`endif
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      rem_sel_q <= 1'b0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      divisor_q <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      rem_sel_q <= rem_sel_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      divisor_q <= divisor_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
    end
  end

`ifdef DIV_RESULT_CACHE_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      signed_q   <= 1'b0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      c_valid_q  <= 1'b0;
      c_signed_q <= 1'b0;
      c_rs1_q    <= '0;
      c_rs2_q    <= '0;
      c_quo_q    <= '0;
      c_rem_q    <= '0;
    end else begin
      signed_q   <= signed_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      c_valid_q  <= c_valid_d;
      c_signed_q <= c_signed_d;
      c_rs1_q    <= c_rs1_d;
      c_rs2_q    <= c_rs2_d;
      c_quo_q    <= c_quo_d;
      c_rem_q    <= c_rem_d;
    end
  end
`endif

  assign busy   = (state_q == StCalc) || (state_q == StFix);
  assign done   = (state_q == StDone);
  assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases plus randomized operations
// compared against an arithmetic reference model (including the optional
// result cache when DIV_RESULT_CACHE_EN is defined).
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: last completed result and last normal-path operands.
  logic [31:0] last_res = '0;
  logic        cvalid = 1'b0;
  logic [31:0] ca = '0;
  logic [31:0] cb = '0;
  logic        cs = 1'b0;

  always #5 clk = ~clk;

  div_unit dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .rs1_data(rs1),
    .rs2_data(rs2),
    .flush   (flush),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic is_special(input logic [1:0] o, input logic [31:0] a,
                                      input logic [31:0] b);
    return (b == 0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 0;
    end else if (!o[0]) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return o[1] ? r : q;
  endfunction

  function automatic logic ref_fast(input logic [1:0] o, input logic [31:0] a,
                                    input logic [31:0] b);
    logic hit;
    hit = 1'b0;
`ifdef DIV_RESULT_CACHE_EN
    hit = cvalid && (a == ca) && (b == cb) && (!o[0] == cs);
`endif
    return is_special(o, a, b) || hit;
  endfunction

  // Issue one operation in cycle 0 and follow it to done.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input string tag);
    logic [31:0] exp;
    logic        fast;
    int          lat;
    int          done_cyc;
    int          busy_cnt;
    logic [31:0] got;
    exp      = ref_result(o, a, b);
    fast     = ref_fast(o, a, b);
    lat      = fast ? 1 : 34;
    done_cyc = 0;
    busy_cnt = 0;
    got      = '0;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    rs1   = a;
    rs2   = b;
    for (int n = 1; n <= 40 && done_cyc == 0; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start = 1'b0;
        rs1   = $urandom;
        rs2   = $urandom;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cyc = n;
        got      = result;
      end
    end
    check_eq({tag, " latency"}, done_cyc, lat);
    check_eq({tag, " result"}, got, exp);
    check_eq({tag, " busy cycles"}, busy_cnt, lat - 1);
    @(negedge clk);
    check_eq({tag, " done pulse"}, {31'b0, done}, 32'd0);
    last_res = exp;
    if (!fast) begin
      cvalid = 1'b1;
      ca     = a;
      cb     = b;
      cs     = !o[0];
    end
  endtask

  // Start an operation and kill it at cycle 10 with flush or reset.
  task automatic abort_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic use_rst, input string tag);
    logic saw_done;
    saw_done = 1'b0;
    if (use_rst) begin
      last_res = '0;
      cvalid   = 1'b0;
    end
    @(negedge clk);
    start = 1'b1;
    op    = o;
    rs1   = a;
    rs2   = b;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (done) saw_done = 1'b1;
      if (n == 10) begin
        check_eq({tag, " busy before kill"}, {31'b0, busy}, 32'd1);
        if (use_rst) rst = 1'b0;
        else flush = 1'b1;
      end
      if (n == 11) begin
        check_eq({tag, " busy after kill"}, {31'b0, busy}, 32'd0);
        check_eq({tag, " result after kill"}, result, last_res);
        rst   = 1'b1;
        flush = 1'b0;
      end
    end
    check_eq({tag, " no done"}, {31'b0, saw_done}, 32'd0);
    check_eq({tag, " result held"}, result, last_res);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  o;
    repeat (3) @(negedge clk);
    check_eq("reset busy", {31'b0, busy}, 32'd0);
    check_eq("reset done", {31'b0, done}, 32'd0);
    check_eq("reset result", result, 32'd0);
    rst = 1'b1;

    do_op(2'b00, 32'd100, 32'd7, "div 100/7");
    abort_op(2'b00, 32'd1000, 32'd3, 1'b0, "flush div");
    do_op(2'b10, 32'hFFFF_FF9C, 32'd7, "rem -100/7");
    do_op(2'b01, 32'd5, 32'd0, "divu 5/0");
    do_op(2'b11, 32'd5, 32'd0, "remu 5/0");
    do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, "div ovf");
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "rem ovf");
    abort_op(2'b00, 32'd1000, 32'd3, 1'b1, "reset div");
    do_op(2'b00, 32'd1000, 32'd3, "div 1000/3");
    do_op(2'b10, 32'd1000, 32'd3, "rem 1000/3");
    do_op(2'b00, 32'd1000, 32'd7, "div 1000/7");

    a = 32'd1000;
    b = 32'd7;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 4))
          0:       a = 32'h8000_0000;
          1:       a = 32'($urandom_range(0, 300)) * (($urandom_range(0, 1) != 0) ? -1 : 1);
          default: a = $urandom;
        endcase
        case ($urandom_range(0, 5))
          0:       b = 32'd0;
          1:       b = 32'hFFFF_FFFF;
          2:       b = 32'($urandom_range(1, 20)) * (($urandom_range(0, 1) != 0) ? -1 : 1);
          default: b = $urandom;
        endcase
      end
      o = 2'($urandom_range(0, 3));
      do_op(o, a, b, $sformatf("rand%0d op%0d", i, o));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
